// File: rtl/paddle_motion.sv
// Two-player paddle position engine: per-frame IDLE/UP/DOWN FSM per paddle with clamping and recenter.
// Optional hold-time speed ramp enabled by defining PADDLE_ACCEL_EN (constant MIN_SPEED moves otherwise).
module paddle_motion #(
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned PADDLE_H     = 80,
    parameter int unsigned Y_W          = 10,
    parameter int unsigned MIN_SPEED    = 2,
    parameter int unsigned MAX_SPEED    = 8,
    parameter int unsigned ACCEL_FRAMES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_tick,
    input  logic           recenter,
    input  logic           cleanup1,
    input  logic           cleandown1,
    input  logic           cleanup2,
    input  logic           cleandown2,
    output logic [Y_W-1:0] paddle1_y,
    output logic [Y_W-1:0] paddle2_y,
    output logic           moving1,
    output logic           moving2
);

    localparam int unsigned LIMIT   = SCREEN_H - PADDLE_H;
    localparam int unsigned CENTER  = LIMIT / 2;
    localparam int unsigned SPEED_W = 4;

    localparam logic [Y_W-1:0]     LIMIT_Y  = Y_W'(LIMIT);
    localparam logic [Y_W-1:0]     CENTER_Y = Y_W'(CENTER);
    localparam logic [SPEED_W-1:0] MIN_SPD  = SPEED_W'(MIN_SPEED);

`ifdef PADDLE_ACCEL_EN
    // One spare count so cnt + 1 never wraps before saturation.
    localparam int unsigned CNT_W = $clog2(ACCEL_FRAMES + 2);
`endif

    if (MIN_SPEED == 0 || MAX_SPEED > 15 || MIN_SPEED > MAX_SPEED ||
        ACCEL_FRAMES == 0 || PADDLE_H >= SCREEN_H || LIMIT >= (2 ** Y_W)) begin : g_bad_cfg
        $error("paddle_motion: invalid parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    // Release of rst_n is re-timed so ticks are only honoured once both flops are set.
    logic [1:0] rst_sync_q;
    logic       run;
    logic       tick_en;
    logic       recenter_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run         = rst_sync_q[1];
    assign tick_en     = frame_tick & run;
    assign recenter_en = recenter & run;

    logic [1:0] up_v;
    logic [1:0] dn_v;

    assign up_v = {cleanup2, cleanup1};
    assign dn_v = {cleandown2, cleandown1};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        state_e             state_q;
        state_e             state_d;
        state_e             dir;
        logic [Y_W-1:0]     y_q;
        logic [Y_W-1:0]     y_d;
        logic               moving_q;
        logic               moving_d;
        logic [SPEED_W-1:0] speed_eff;
        logic [Y_W:0]       sum_down;
`ifdef PADDLE_ACCEL_EN
        logic [SPEED_W-1:0] speed_q;
        logic [SPEED_W-1:0] speed_d;
        logic [CNT_W-1:0]   cnt_q;
        logic [CNT_W-1:0]   cnt_d;
        logic [CNT_W-1:0]   cnt_next;
`endif

        // Both or neither button pressed decodes to IDLE.
        always_comb begin
            dir = ST_IDLE;
            if (up_v[ch] && !dn_v[ch]) begin
                dir = ST_UP;
            end else if (dn_v[ch] && !up_v[ch]) begin
                dir = ST_DOWN;
            end
        end

        always_comb begin
            state_d   = state_q;
            y_d       = y_q;
            moving_d  = moving_q;
            speed_eff = MIN_SPD;
`ifdef PADDLE_ACCEL_EN
            speed_d   = speed_q;
            cnt_d     = cnt_q;
            cnt_next  = CNT_W'(1);
            if (dir == state_q) begin
                speed_eff = speed_q;
                cnt_next  = cnt_q + CNT_W'(1);
            end
`endif
            sum_down = {1'b0, y_q} + (Y_W + 1)'(speed_eff);

            if (recenter_en) begin
                state_d  = ST_IDLE;
                y_d      = CENTER_Y;
                moving_d = 1'b0;
`ifdef PADDLE_ACCEL_EN
                speed_d  = MIN_SPD;
                cnt_d    = '0;
`endif
            end else if (tick_en) begin
                state_d  = dir;
                moving_d = (dir != ST_IDLE);
                case (dir)
                    ST_UP: begin
                        y_d = (y_q < Y_W'(speed_eff)) ? '0 : y_q - Y_W'(speed_eff);
                    end
                    ST_DOWN: begin
                        y_d = (sum_down > (Y_W + 1)'(LIMIT)) ? LIMIT_Y : sum_down[Y_W-1:0];
                    end
                    default: begin
                        y_d = y_q;
                    end
                endcase
`ifdef PADDLE_ACCEL_EN
                // Ramp keeps running even while the position is pinned at a clamp limit.
                if (dir == ST_IDLE) begin
                    speed_d = MIN_SPD;
                    cnt_d   = '0;
                end else if (cnt_next == CNT_W'(ACCEL_FRAMES) &&
                             speed_eff < SPEED_W'(MAX_SPEED)) begin
                    speed_d = speed_eff + SPEED_W'(1);
                    cnt_d   = '0;
                end else begin
                    speed_d = speed_eff;
                    cnt_d   = (cnt_next > CNT_W'(ACCEL_FRAMES)) ? CNT_W'(ACCEL_FRAMES) : cnt_next;
                end
`endif
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= ST_IDLE;
                y_q      <= CENTER_Y;
                moving_q <= 1'b0;
`ifdef PADDLE_ACCEL_EN
                speed_q  <= MIN_SPD;
                cnt_q    <= '0;
`endif
            end else begin
                state_q  <= state_d;
                y_q      <= y_d;
                moving_q <= moving_d;
`ifdef PADDLE_ACCEL_EN
                speed_q  <= speed_d;
                cnt_q    <= cnt_d;
`endif
            end
        end
    end

    assign paddle1_y = g_ch[0].y_q;
    assign paddle2_y = g_ch[1].y_q;
    assign moving1   = g_ch[0].moving_q;
    assign moving2   = g_ch[1].moving_q;

endmodule

// File: tb/tb_paddle_motion.sv
// Directed bench for paddle_motion: reset, ramp, clamp, reversal, both-pressed, recenter, mid-move reset.
module tb_paddle_motion;

`ifdef PADDLE_ACCEL_EN
    localparam int unsigned EXP_RAMP = 172;
    localparam int unsigned EXP_R2   = 183;
`else
    localparam int unsigned EXP_RAMP = 180;
    localparam int unsigned EXP_R2   = 186;
`endif

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       recenter;
    logic       cu1;
    logic       cd1;
    logic       cu2;
    logic       cd2;
    logic [9:0] p1_y;
    logic [9:0] p2_y;
    logic       m1;
    logic       m2;

    int checks   = 0;
    int failures = 0;

    paddle_motion dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .recenter   (recenter),
        .cleanup1   (cu1),
        .cleandown1 (cd1),
        .cleanup2   (cu2),
        .cleandown2 (cd2),
        .paddle1_y  (p1_y),
        .paddle2_y  (p2_y),
        .moving1    (m1),
        .moving2    (m2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; frame_tick = 1'b0; recenter = 1'b0;
        cu1 = 1'b0; cd1 = 1'b0; cu2 = 1'b0; cd2 = 1'b0;

        // Asynchronous reset assertion before any clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("rst_y1", 32'(p1_y), 200);
        chk("rst_y2", 32'(p2_y), 200);
        chk("rst_m1", 32'(m1), 0);
        chk("rst_m2", 32'(m2), 0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(3);

        // No buttons, 5 ticks
        repeat (5) do_tick();
        chk("idle_y1", 32'(p1_y), 200);
        chk("idle_y2", 32'(p2_y), 200);
        chk("idle_m1", 32'(m1), 0);
        chk("idle_m2", 32'(m2), 0);

        // Hold up on player 1 for 10 ticks
        cu1 = 1'b1;
        repeat (10) do_tick();
        chk("ramp_y1", 32'(p1_y), EXP_RAMP);
        chk("ramp_m1", 32'(m1), 1);
        chk("ramp_y2", 32'(p2_y), 200);
        chk("ramp_m2", 32'(m2), 0);

        // Input changes between ticks are ignored
        cu1 = 1'b0; cd1 = 1'b1;
        idle_cycles(4);
        chk("notick_y1", 32'(p1_y), EXP_RAMP);
        chk("notick_m1", 32'(m1), 1);

        // Both pressed: idle, then up-only restarts at minimum speed
        cu1 = 1'b1; cd1 = 1'b1;
        repeat (3) do_tick();
        chk("both_y1", 32'(p1_y), EXP_RAMP);
        chk("both_m1", 32'(m1), 0);
        cd1 = 1'b0;
        do_tick();
        chk("restart_y1", 32'(p1_y), EXP_RAMP - 2);
        chk("restart_m1", 32'(m1), 1);

        // Player 2 down to the clamp, player 1 released
        cu1 = 1'b0; cd2 = 1'b1;
        for (int i = 0; i < 110; i++) begin
            do_tick();
            chk("y2_le_lim", 32'(p2_y <= 10'd400), 1);
        end
        chk("clamp_y2", 32'(p2_y), 400);
        chk("clamp_m2", 32'(m2), 1);
        chk("clamp_y1", 32'(p1_y), EXP_RAMP - 2);
        chk("clamp_m1", 32'(m1), 0);

        // Reversal moves minimum speed
        cd2 = 1'b0; cu2 = 1'b1;
        do_tick();
        chk("rev_y2", 32'(p2_y), 398);
        chk("rev_m2", 32'(m2), 1);

        // Recenter with a coincident tick and buttons held
        cu1 = 1'b1;
        @(negedge clk);
        frame_tick = 1'b1; recenter = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; recenter = 1'b0;
        chk("rc_y1", 32'(p1_y), 200);
        chk("rc_y2", 32'(p2_y), 200);
        chk("rc_m1", 32'(m1), 0);
        chk("rc_m2", 32'(m2), 0);

        cu2 = 1'b0;
        do_tick();
        chk("post_rc_y1", 32'(p1_y), 198);
        chk("post_rc_m1", 32'(m1), 1);
        chk("post_rc_y2", 32'(p2_y), 200);
        chk("post_rc_m2", 32'(m2), 0);

        repeat (6) do_tick();
        chk("ramp2_y1", 32'(p1_y), EXP_R2);

        // Reset pulsed between ticks mid-ramp
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_y1", 32'(p1_y), 200);
        chk("mrst_m1", 32'(m1), 0);
        idle_cycles(2);
        rst_n = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("sync_win_y1", 32'(p1_y), 200);
        idle_cycles(3);
        do_tick();
        chk("mrst_mv_y1", 32'(p1_y), 198);
        chk("mrst_mv_m1", 32'(m1), 1);

        // Back-to-back ticks after an up-to-down reversal
        cu1 = 1'b0; cd1 = 1'b1;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        chk("b2b_y1_0", 32'(p1_y), 200);
        @(negedge clk);
        chk("b2b_y1_1", 32'(p1_y), 202);
        @(negedge clk);
        frame_tick = 1'b0;
        chk("b2b_y1_2", 32'(p1_y), 204);
        @(negedge clk);
        chk("b2b_hold", 32'(p1_y), 204);
        chk("b2b_m1", 32'(m1), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
